// File: rtl/pipeline_stage_skid_if.sv
// pipeline_stage_skid_if
//   Bundles the upstream handshake, downstream handshake, hazard controls and
//   the stall counter of one inter-stage register boundary.
//   Signals:
//     inValid/inReady/inInstr/inPCCounter      upstream handshake and payload
//     outValid/outReady/outInstr/outPCCounter  downstream handshake and payload
//     hazardIFDWrite                           stall: hold output, no transfer
//     hazardIFFlush                            flush: discard held and incoming
//     stallCount                               saturating stalled-output cycles
//   Modports:
//     master  the environment around the stage (drives stage inputs)
//     slave   the stage itself
interface pipeline_stage_skid_if #(
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned STALL_CNT_W = 8
);
    logic                   inValid;
    logic                   inReady;
    logic [INSTR_W-1:0]     inInstr;
    logic [PC_W-1:0]        inPCCounter;
    logic                   outValid;
    logic                   outReady;
    logic [INSTR_W-1:0]     outInstr;
    logic [PC_W-1:0]        outPCCounter;
    logic                   hazardIFDWrite;
    logic                   hazardIFFlush;
    logic [STALL_CNT_W-1:0] stallCount;

    modport master (
        output inValid, inInstr, inPCCounter, outReady, hazardIFDWrite, hazardIFFlush,
        input  inReady, outValid, outInstr, outPCCounter, stallCount
    );

    modport slave (
        input  inValid, inInstr, inPCCounter, outReady, hazardIFDWrite, hazardIFFlush,
        output inReady, outValid, outInstr, outPCCounter, stallCount
    );
endinterface

// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid
//   Inter-stage register (IF/ID, ID/EX, ...) carrying an instruction word and
//   its PC through a 2-entry skid buffer with valid/ready handshakes on both
//   sides, hazard write-hold, flush-to-NOP and a saturating stall counter.
//   Ports:
//     Clk  clock, all state changes on the rising edge
//     Rst  asynchronous active-high reset
//     bus  pipeline_stage_skid_if.slave (handshakes, payload, hazards, stallCount)
//   inReady and outValid are decoded from registered state only, so there is
//   no combinational path from outReady or the hazard inputs to inReady.
module pipeline_stage_skid #(
    parameter int unsigned       INSTR_W     = 32,
    parameter int unsigned       PC_W        = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = '0,
    parameter int unsigned       STALL_CNT_W = 8
) (
    input logic                  Clk,
    input logic                  Rst,
    pipeline_stage_skid_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t                 state;
    logic [INSTR_W-1:0]     main_instr;
    logic [PC_W-1:0]        main_pc;
    logic [INSTR_W-1:0]     skid_instr;
    logic [PC_W-1:0]        skid_pc;
    logic [STALL_CNT_W-1:0] stall_cnt;

    logic acc;
    logic push;

    assign bus.inReady      = (state != SKID);
    assign bus.outValid     = (state != EMPTY);
    assign bus.outInstr     = main_instr;
    assign bus.outPCCounter = main_pc;
    assign bus.stallCount   = stall_cnt;

    assign acc  = bus.outValid & bus.outReady & ~bus.hazardIFDWrite;
    assign push = bus.inValid & bus.inReady;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= EMPTY;
            main_instr <= NOP_INSTR;
            main_pc    <= '0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            stall_cnt  <= '0;
        end else if (bus.hazardIFFlush) begin
            // Flush overrides push, acc and stall; a concurrent push is dropped.
            state      <= EMPTY;
            main_instr <= NOP_INSTR;
            main_pc    <= '0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            stall_cnt  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_instr <= bus.inInstr;
                        main_pc    <= bus.inPCCounter;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (push && acc) begin
                        main_instr <= bus.inInstr;
                        main_pc    <= bus.inPCCounter;
                    end else if (acc) begin
                        main_instr <= NOP_INSTR;
                        main_pc    <= '0;
                        state      <= EMPTY;
                    end else if (push) begin
                        // Output held (backpressure or stall): park the new entry.
                        skid_instr <= bus.inInstr;
                        skid_pc    <= bus.inPCCounter;
                        state      <= SKID;
                    end
                end
                SKID: begin
                    if (acc) begin
                        main_instr <= skid_instr;
                        main_pc    <= skid_pc;
                        skid_instr <= NOP_INSTR;
                        skid_pc    <= '0;
                        state      <= FULL;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase

            if (acc) begin
                stall_cnt <= '0;
            end else if ((state != EMPTY) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipeline_stage_skid.sv
// tb_pipeline_stage_skid
//   Scoreboard bench: the driver issues stimulus and queues every entry the
//   stage will accept; the monitor compares DUT outputs each cycle against the
//   queue head / occupancy model and pops on each downstream transfer.
module tb_pipeline_stage_skid;
    localparam int unsigned IW = 32;
    localparam int unsigned PW = 32;
    localparam int unsigned CW = 2;
    localparam logic [IW-1:0] NOP = 32'h0000_0013;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [PW-1:0] pc;
    } ent_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    always #5 Clk = ~Clk;

    pipeline_stage_skid_if #(.INSTR_W(IW), .PC_W(PW), .STALL_CNT_W(CW)) bus ();

    pipeline_stage_skid #(
        .INSTR_W(IW),
        .PC_W(PW),
        .NOP_INSTR(NOP),
        .STALL_CNT_W(CW)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    ent_t exp_q[$];
    int   occ   = 0;   // entries currently held by the stage
    int   cnt_m = 0;   // expected stallCount
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs shortly after the rising edge and queue the
    // entry if the stage will accept it at the next edge.
    task automatic drive(input logic v, input logic [IW-1:0] instr, input logic [PW-1:0] pc,
                         input logic ordy, input logic st, input logic fl);
        ent_t e;
        @(posedge Clk);
        #2;
        bus.inValid        = v;
        bus.inInstr        = instr;
        bus.inPCCounter    = pc;
        bus.outReady       = ordy;
        bus.hazardIFDWrite = st;
        bus.hazardIFFlush  = fl;
        if (v && !fl && occ < 2) begin
            e.instr = instr;
            e.pc    = pc;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must react without a clock.
    task automatic async_reset();
        @(posedge Clk);
        #7;
        Rst = 1'b1;
        bus.inValid        = 1'b0;
        bus.outReady       = 1'b0;
        bus.hazardIFDWrite = 1'b0;
        bus.hazardIFFlush  = 1'b0;
        exp_q.delete();
        occ   = 0;
        cnt_m = 0;
        #1;
        check("rst_outValid", 64'(bus.outValid), 64'(0));
        check("rst_inReady", 64'(bus.inReady), 64'(1));
        check("rst_outInstr", 64'(bus.outInstr), 64'(NOP));
        check("rst_outPC", 64'(bus.outPCCounter), 64'(0));
        check("rst_stallCount", 64'(bus.stallCount), 64'(0));
        @(posedge Clk);
        #2;
        Rst = 1'b0;
    endtask

    // Monitor: compare at the falling edge, then advance the model to the
    // state expected after the coming rising edge.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                bit acc;
                bit push;
                int occ_prev;
                check("outValid", 64'(bus.outValid), 64'(occ > 0));
                check("inReady", 64'(bus.inReady), 64'(occ < 2));
                check("stallCount", 64'(bus.stallCount), 64'(cnt_m));
                if (occ > 0 && exp_q.size() > 0) begin
                    check("outInstr", 64'(bus.outInstr), 64'(exp_q[0].instr));
                    check("outPC", 64'(bus.outPCCounter), 64'(exp_q[0].pc));
                end else begin
                    check("outInstr_nop", 64'(bus.outInstr), 64'(NOP));
                    check("outPC_zero", 64'(bus.outPCCounter), 64'(0));
                end

                occ_prev = occ;
                acc  = (occ > 0) && bus.outReady && !bus.hazardIFDWrite;
                push = bus.inValid && (occ < 2);
                if (acc) begin
                    void'(exp_q.pop_front());
                    occ--;
                end
                if (bus.hazardIFFlush) begin
                    exp_q.delete();
                    occ   = 0;
                    cnt_m = 0;
                end else begin
                    if (push) occ++;
                    if (acc) cnt_m = 0;
                    else if (occ_prev > 0 && cnt_m < CMAX) cnt_m++;
                end
            end
        end
    end

    initial begin
        bus.inValid        = 1'b0;
        bus.inInstr        = '0;
        bus.inPCCounter    = '0;
        bus.outReady       = 1'b0;
        bus.hazardIFDWrite = 1'b0;
        bus.hazardIFFlush  = 1'b0;
        #1;
        Rst = 1'b1;
        #1;
        check("init_outValid", 64'(bus.outValid), 64'(0));
        check("init_inReady", 64'(bus.inReady), 64'(1));
        check("init_outInstr", 64'(bus.outInstr), 64'(NOP));
        repeat (2) @(posedge Clk);
        #2;
        Rst = 1'b0;

        // Reset then stream
        for (int i = 0; i < 4; i++)
            drive(1'b1, IW'(32'h11 + i), PW'(4 * i), 1'b1, 1'b0, 1'b0);
        idle(2);

        // Backpressure into skid, then drain in order
        drive(1'b1, 32'hA, 32'h100, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 32'h104, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 32'h108, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 32'h108, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 32'h108, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 32'h108, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Hazard stall with downstream ready
        drive(1'b1, 32'h20, 32'h40, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Flush while in SKID with a concurrent push
        drive(1'b1, 32'h30, 32'h80, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h31, 32'h84, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h32, 32'h88, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Saturation, then stall and flush together
        drive(1'b1, 32'h40, 32'hC0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Async reset in SKID, then push from EMPTY
        drive(1'b1, 32'h50, 32'h200, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h51, 32'h204, 1'b0, 1'b0, 1'b0);
        async_reset();
        drive(1'b1, 32'h60, 32'h300, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, IW'($urandom), PW'($urandom),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 31) == 0);
            end
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_stage_skid.md
Name: pipeline_stage_skid

Overview:
- Parametrised successor to the IF/ID stage register, for any inter-stage boundary (IF/ID, ID/EX, ...).
- Carries an instruction word and PC through a 2-entry skid buffer with valid/ready handshakes.
- Supports hazard stall (write-hold) and flush-to-NOP.
- Exports a saturating stall-cycle counter for performance debug.

Parameters:
- INSTR_W, 32, instruction word width.
- PC_W, 32, PC counter width.
- NOP_INSTR, 0 (INSTR_W bits), word presented on outInstr when the stage is empty, flushed or reset.
- STALL_CNT_W, 8, width of the stall-cycle counter.

Ports:
- Clk  input  1  clock; all state changes on its rising edge.
- Rst  input  1  asynchronous active-high reset.
- inValid  input  1  upstream has a valid instr/PC this cycle.
- inReady  output  1  stage can accept; transfer when inValid & inReady.
- inInstr  input  INSTR_W  incoming instruction.
- inPCCounter  input  PC_W  incoming PC.
- outValid  output  1  outInstr/outPCCounter are valid.
- outReady  input  1  downstream can accept.
- outInstr  output  INSTR_W  registered instruction.
- outPCCounter  output  PC_W  registered PC.
- hazardIFDWrite  input  1  stall: hold the output, no downstream transfer.
- hazardIFFlush  input  1  flush: discard all held and incoming entries.
- stallCount  output  STALL_CNT_W  consecutive stalled-output cycles, saturating.

Behaviour:
- Reset (async, Rst=1): state EMPTY, outValid=0, outInstr=NOP_INSTR, outPCCounter=0, skid regs cleared, stallCount=0. inReady=1 immediately. Rst mid-transfer drops everything; no partial updates.
- acc = outValid & outReady & ~hazardIFDWrite (downstream transfer this cycle).
- push = inValid & inReady.
- inReady = (state != SKID). It is a pure function of registered state, with no combinational path from outReady or hazard inputs.
- Latency: a pushed entry appears on the outputs 1 cycle after push when the stage is EMPTY or accepting.
- Ordering: strict FIFO order. Entries are never duplicated or dropped except by flush.
- State EMPTY (outValid=0):
  - push: main<=in, go to FULL.
  - else hold; outputs stay NOP_INSTR/0.
- State FULL (main valid, outValid=1):
  - push & acc: main<=in, stay FULL.
  - acc only: main<=NOP_INSTR/0, go to EMPTY.
  - push & ~acc: skid<=in, go to SKID.
  - neither: hold.
- State SKID (main and skid valid, inReady=0):
  - acc: main<=skid, clear skid, go to FULL.
  - else hold both.
- Flush (hazardIFFlush=1) is synchronous and highest priority, overriding push, acc and stall:
  - next state EMPTY, main and skid <= NOP_INSTR/0, outValid<=0.
  - A push coinciding with flush is consumed and discarded.
  - The output entry is still seen as transferred by downstream if acc was true that cycle.
- Stall and flush both high: flush wins.
- Stall alone: outputs and state bits frozen, except that a push in FULL still fills skid (inReady is already 1).
- stallCount:
  - +1 each cycle with outValid & ~acc & ~hazardIFFlush, saturating at all-ones (no wrap).
  - Cleared to 0 on acc, flush or reset.
  - Holds while EMPTY.
- No X on outputs after reset; all regs reset.

Test Plan:
- Reset then stream: Rst pulse, then inValid=1 with instr 0x00000011..0x00000014 and PC 0,4,8,12, outReady=1 -> outValid rises 1 cycle after first push; outputs 0x11/0, 0x12/4, 0x13/8, 0x14/12 on consecutive cycles; inReady stays 1; stallCount=0.
- Backpressure skid: stream A(0xA,PC 0x100), B(0xB,0x104), drop outReady for 3 cycles after A reaches output -> B captured in skid, inReady=0 next cycle, C held off; outReady back -> A, B, C delivered in order; stallCount reads 1,2,3 then 0.
- Hazard stall: FULL with 0x20/0x40, hazardIFDWrite=1 for 2 cycles while outReady=1 -> outputs frozen at 0x20/0x40, stallCount 2, no loss; release -> resumes in order.
- Flush in SKID: fill main=0x30, skid=0x31, pulse hazardIFFlush with concurrent inValid 0x32 -> next cycle outValid=0, outInstr=NOP_INSTR, outPCCounter=0, inReady=1; 0x31 and 0x32 never appear.
- Flush vs stall and saturation (STALL_CNT_W=2): hold outReady=0 for 5 cycles -> stallCount 1,2,3,3,3; then hazardIFDWrite=1 and hazardIFFlush=1 together -> flush wins, EMPTY, stallCount=0.
- Async reset mid-SKID: assert Rst between clock edges -> outputs go to reset values immediately, without waiting for a clock edge; first push after release behaves as from EMPTY.
